// File: rtl/regfile_wb_queue.sv
// Write-back queue for the 16x32 register file write port: an in-order result FIFO feeding a registered write stage.
// Optional forwarding of pending values to two read ports is built when WBQ_FWD_EN is defined.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [ADDR_W-1:0]         res_wn,
  input  logic [DATA_W-1:0]         res_wd,
  input  logic                      wb_hold,
  output logic                      wb_en,
  output logic [ADDR_W-1:0]         wb_wn,
  output logic [DATA_W-1:0]         wb_wd,
  input  logic [ADDR_W-1:0]         q_rn1,
  input  logic [ADDR_W-1:0]         q_rn2,
  output logic                      fwd1_hit,
  output logic                      fwd2_hit,
  output logic [DATA_W-1:0]         fwd1_data,
  output logic [DATA_W-1:0]         fwd2_data,
  output logic [(2**ADDR_W)-1:0]    busy,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);

  // Handshake: a result transfers on a rising edge where res_valid && res_ready;
  // res_ready depends only on occupancy, never on res_valid.
  logic [ADDR_W-1:0] wn_mem [DEPTH];
  logic [DATA_W-1:0] wd_mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic              push, pop;

  assign res_ready = (count < (PW+1)'(DEPTH));
  assign push      = res_valid && res_ready && (res_wn != '0);
  assign pop       = !wb_hold && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      wn_mem[tail] <= res_wn;
      wd_mem[tail] <= res_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      wb_en <= 1'b0;
      wb_wn <= '0;
      wb_wd <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        wb_en <= 1'b1;
        wb_wn <= wn_mem[head];
        wb_wd <= wd_mem[head];
        head  <= head + 1'b1;
      end else begin
        wb_en <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending set: FIFO entries at offsets 0..count-1 from head, plus the write stage.
  logic [PW-1:0] b_idx;
  always_comb begin
    busy  = '0;
    b_idx = '0;
    if (wb_en) busy[wb_wn] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      b_idx = head + PW'(i);
      if ((PW+1)'(i) < count) busy[wn_mem[b_idx]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

`ifdef WBQ_FWD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] rn);
    logic [DATA_W:0] r;
    logic [PW-1:0]   idx;
    r = '0;
    if (wb_en && (wb_wn == rn)) r = {1'b1, wb_wd};
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (wn_mem[idx] == rn)) r = {1'b1, wd_mem[idx]};
    end
    if (rn == '0) r = '0;
    return r;
  endfunction

  assign {fwd1_hit, fwd1_data} = lookup(q_rn1);
  assign {fwd2_hit, fwd2_data} = lookup(q_rn2);
`else
  logic unused_rn;
  assign unused_rn = ^{q_rn1, q_rn2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic, checked against a queue-based reference model.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4, DATA_W = 32, ADDR_W = 4, EW = ADDR_W + DATA_W;

  logic              clk = 1'b0, rst = 1'b1;
  logic              res_valid = 1'b0, res_ready, wb_hold = 1'b0;
  logic [ADDR_W-1:0] res_wn = '0, q_rn1 = '0, q_rn2 = '0, wb_wn;
  logic [DATA_W-1:0] res_wd = '0, wb_wd, fwd1_data, fwd2_data;
  logic              wb_en, fwd1_hit, fwd2_hit;
  logic [15:0]       busy;
  logic [2:0]        count;

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_wn(res_wn), .res_wd(res_wd), .wb_hold(wb_hold), .wb_en(wb_en),
    .wb_wn(wb_wn), .wb_wd(wb_wd), .q_rn1(q_rn1), .q_rn2(q_rn2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data),
    .fwd2_data(fwd2_data), .busy(busy), .count(count)
  );

  // clock
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [EW-1:0] exp_q[$];    // writes the register file must see, in order
  logic [EW-1:0] model_q[$];  // reference FIFO contents
  logic              m_wb_en = 1'b0;
  logic [ADDR_W-1:0] m_wb_wn = '0;
  logic [DATA_W-1:0] m_wb_wd = '0;
  logic [EW-1:0]     m_e;
  bit                m_pop, m_push;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: in-order queue plus one write-stage slot
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      m_wb_en = 1'b0;
    end else begin
      m_pop  = !wb_hold && (model_q.size() > 0);
      m_push = res_valid && (model_q.size() < DEPTH) && (res_wn != 0);
      if (m_pop) begin
        m_e = model_q.pop_front();
        m_wb_en = 1'b1;
        {m_wb_wn, m_wb_wd} = m_e;
        exp_q.push_back(m_e);
      end else begin
        m_wb_en = 1'b0;
      end
      if (m_push) model_q.push_back({res_wn, res_wd});
    end
  end

  function automatic logic [15:0] busy_model();
    logic [15:0] b = '0;
    foreach (model_q[i]) b[model_q[i][EW-1:DATA_W]] = 1'b1;
    if (m_wb_en) b[m_wb_wn] = 1'b1;
    return b;
  endfunction

  function automatic logic [DATA_W:0] fwd_model(input logic [ADDR_W-1:0] rn);
`ifdef WBQ_FWD_EN
    if (rn == 0) return '0;
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i][EW-1:DATA_W] == rn) return {1'b1, model_q[i][DATA_W-1:0]};
    if (m_wb_en && (m_wb_wn == rn)) return {1'b1, m_wb_wd};
`endif
    return '0;
  endfunction

  // monitor / scoreboard
  logic [EW-1:0] got_e;
  always @(negedge clk) begin
    if (!rst) begin
      check("wb_en", wb_en, m_wb_en);
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          got_e = exp_q.pop_front();
          check("wb_write", {wb_wn, wb_wd}, got_e);
        end
      end
      check("count", count, model_q.size());
      check("res_ready", res_ready, model_q.size() < DEPTH);
      check("busy", busy, busy_model());
      check("fwd1", {fwd1_hit, fwd1_data}, fwd_model(q_rn1));
      check("fwd2", {fwd2_hit, fwd2_data}, fwd_model(q_rn2));
    end
  end

  // driver: one call = inputs for the next rising edge
  task automatic drive(input bit v, input logic [ADDR_W-1:0] wn, input logic [DATA_W-1:0] wd,
                       input bit hold, input logic [ADDR_W-1:0] rn1, input logic [ADDR_W-1:0] rn2);
    @(negedge clk);
    #2;
    res_valid = v; res_wn = wn; res_wd = wd; wb_hold = hold; q_rn1 = rn1; q_rn2 = rn2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    check("rst_wb_en", wb_en, 0);
    check("rst_count", count, 0);
    check("rst_ready", res_ready, 1);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // single write
    drive(1, 3, 32'hDEADBEEF, 0, 3, 0);
    idle(4);

    // full under hold, fifth offer refused, then drain
    for (int k = 1; k <= 4; k++) drive(1, 4'(k), $urandom, 1, 4'(k), 2);
    drive(1, 9, 32'h9999, 1, 9, 0);
    check("full_ready", res_ready, 0);
    idle(7);

    // forwarding: youngest of two writes to r5, r0 never hits
    drive(1, 5, 32'h11, 1, 5, 0);
    drive(1, 5, 32'h22, 1, 5, 0);
    drive(0, 0, 0, 1, 5, 0);
    drive(0, 0, 0, 0, 5, 0);
    idle(4);

    // zero register: handshake completes, nothing queued
    drive(1, 0, 32'hFFFF, 0, 0, 0);
    #1 check("zero_ready", res_ready, 1);
    idle(3);

    // simultaneous push/pop with two entries queued
    drive(1, 1, 32'hA1, 1, 7, 1);
    drive(1, 2, 32'hA2, 1, 7, 2);
    drive(1, 7, 32'hA7, 0, 7, 2);
    idle(5);

    // reset mid-stream with count=3 and wb_en=1
    for (int k = 1; k <= 4; k++) drive(1, 4'(k + 10), $urandom, 1, 12, 13);
    drive(0, 0, 0, 0, 12, 13);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_wb_en", wb_en, 0);
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_hit1", fwd1_hit, 0);
    check("arst_hit2", fwd2_hit, 0);
    check("arst_ready", res_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;

    // random traffic
    for (int n = 0; n < 400; n++)
      drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(10);
    check("sb_drained", exp_q.size(), 0);
    check("model_empty", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue and scheduler for the 16×32 register file write port. Execution and load units hand in results as (register number, data) through a valid/ready handshake. The block buffers them in a small in-order FIFO and drives the register file's write enable, write number and write data, one write per cycle. It also publishes a per-register pending-write vector and, optionally, forwarding of not-yet-written values for two read ports.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- DATA_W, 32: result data width
- ADDR_W, 4: register number width (16 registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- res_valid  in  1  result offered
- res_ready  out  1  queue can accept; equals (count < DEPTH)
- res_wn  in  ADDR_W  destination register number
- res_wd  in  DATA_W  result data
- wb_hold  in  1  suppress draining (write port borrowed elsewhere)
- wb_en  out  1  to register file EnRW; registered
- wb_wn  out  ADDR_W  to register file WN; registered
- wb_wd  out  DATA_W  to register file WD; registered
- q_rn1, q_rn2  in  ADDR_W  read numbers being issued to the register file
- fwd1_hit, fwd2_hit  out  1  a pending write exists for q_rn1 / q_rn2
- fwd1_data, fwd2_data  out  DATA_W  youngest pending value for q_rn1 / q_rn2
- busy  out  2**ADDR_W  bit r set while any write to r is pending
- count  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Push: a result is accepted when res_valid && res_ready at a rising edge. res_wn == 0 is accepted and discarded: no enqueue, no count change.
- Pop: at each rising edge, if !wb_hold and count > 0, the head entry is loaded into wb_en=1/wb_wn/wb_wd and removed. Otherwise wb_en is cleared to 0. wb_wn and wb_wd hold their last values.
- Push and pop in the same edge: both take effect, count unchanged. A push when full cannot occur because ready is low; there is no same-cycle full bypass.
- Order: results are written strictly in acceptance order. Duplicate destinations are all written, and the last one wins in the register file.
- Pending set: all valid FIFO entries, plus the wb stage while wb_en=1.
- busy: combinational OR over the pending set. Bit 0 is never set.
- Forwarding: combinational lookup of q_rnX against the pending set. Priority goes to the youngest: FIFO tail-1 down to head, then the wb stage. q_rnX == 0 never hits; its data reads 0. On no hit, the data output is 0.
- Pointers wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0.
- Reset (async, any time): FIFO emptied, count=0, wb_en=0, wb_wn=0, wb_wd=0, busy=0, fwd hits=0, res_ready=1. In-flight results are dropped; wb_en falls immediately without waiting for a clock.

## Timing
- Result accepted at edge N with an empty queue and no hold: wb_en=1 after edge N+1. The register file commits on the falling edge between N+1 and N+2. busy is set after N and cleared after N+2 if no further pop occurs.
- Throughput: one write per cycle. Sustained push rate equals drain rate, so the queue only fills under wb_hold.
- res_ready, busy, fwd* are combinational from state and q_rnX. There is no combinational path from res_valid to res_ready.
- wb_hold sampled high at edge N: no pop at N, wb_en=0 after N.

## Configuration
- WBQ_FWD_EN defined: forwarding comparators and muxes are built; fwd1/fwd2 outputs behave as in Operation.
- WBQ_FWD_EN undefined: no forwarding logic; fwd1_hit and fwd2_hit are tied 0, and fwd1_data and fwd2_data are tied 0. busy and all queue behaviour are unchanged.

## Test plan
- Reset mid-stream: assert rst with count=3 and wb_en=1 → wb_en, count, busy and fwd hits drop to 0 asynchronously; res_ready=1.
- Single write: push wn=3 wd=0xDEADBEEF at edge N → after N+1, wb_en=1, wb_wn=3, wb_wd=0xDEADBEEF; after N+2, wb_en=0; busy[3] high only between N and N+2.
- Full/hold: wb_hold=1, push wn=1..4 → count=4 and res_ready=0; a fifth offer is not taken. Release hold → writes to 1,2,3,4 on four consecutive cycles, then wb_en=0.
- Forwarding (WBQ_FWD_EN): under hold, push wn=5 0x11 then wn=5 0x22; q_rn1=5 → fwd1_hit=1, fwd1_data=0x22. q_rn2=0 → fwd2_hit=0, fwd2_data=0. Rebuild without macro → both hits 0.
- Zero register: push wn=0 wd=0xFFFF → accepted (handshake completes); count unchanged, no wb_en pulse, busy[0]=0.
- Simultaneous push/pop: count=2, no hold, push wn=7 → count stays 2 and the head is written. Entry 7 is written two cycles later.
